// File: rtl/stopwatch_button_ctrl.sv
// Stopwatch button front-end: two-flop synchronisers, per-button debounce,
// rising-edge command pulses with pause-over-start arbitration.
// Optional long-press clear is built only when LONG_PRESS_CLEAR_EN is defined;
// otherwise clear is tied low.
module stopwatch_button_ctrl #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_start_i,
    input  logic btn_pause_i,
    output logic start,
    output logic pause,
    output logic clear,
    output logic start_lvl,
    output logic pause_lvl
);

    // Bit 0 = start button, bit 1 = pause button throughout.
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    s1_q, s2_q;
    logic [1:0]    db_q, db_d;
    logic [1:0]    rise;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          start_q, pause_q;

    // Two-flop synchronisers for both raw buttons.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 2'b00;
            s2_q <= 2'b00;
        end else begin
            s1_q <= {btn_pause_i, btn_start_i};
            s2_q <= s1_q;
        end
    end

    // Debounce next state: accept a new level only after it has disagreed
    // with the current level for DEBOUNCE_CYCLES consecutive edges.
    always_comb begin
        db_d = db_q;
        for (int b = 0; b < 2; b++) begin
            cnt_d[b] = cnt_q[b];
            if (s2_q[b] == db_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_MAX) begin
                db_d[b]  = s2_q[b];
                cnt_d[b] = '0;
            end else begin
                cnt_d[b] = cnt_q[b] + CW'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_q <= 2'b00;
            for (int b = 0; b < 2; b++) cnt_q[b] <= '0;
        end else begin
            db_q <= db_d;
            for (int b = 0; b < 2; b++) cnt_q[b] <= cnt_d[b];
        end
    end

    // A press is the 0->1 transition of the debounced level, seen on the
    // same edge that updates the level.
    assign rise = db_d & ~db_q;

    // Command pulses; a simultaneous start is dropped in favour of pause.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            pause_q <= rise[1];
            start_q <= rise[0] & ~rise[1];
        end
    end

    assign start     = start_q;
    assign pause     = pause_q;
    assign start_lvl = db_q[0];
    assign pause_lvl = db_q[1];

`ifdef LONG_PRESS_CLEAR_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [HW-1:0] HOLD_FIRE = HW'(LONG_PRESS_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_CYCLES);

    logic [HW-1:0] hold_q;
    logic          clear_q;

    // Hold counter runs while pause is held, fires once, then saturates
    // so a continued hold cannot repeat the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            clear_q <= 1'b0;
        end else if (!db_q[1]) begin
            hold_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= (hold_q == HOLD_FIRE);
            if (hold_q != HOLD_SAT) hold_q <= hold_q + HW'(1);
        end
    end

    assign clear = clear_q;
`else
    assign clear = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_button_ctrl.sv
// Directed bench for stopwatch_button_ctrl with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=16. Expected pulse edges are hand-computed: a press
// sampled at edge 0 gives a pulse visible just after edge 5; a long pause
// hold gives clear just after edge 21.
module tb_stopwatch_button_ctrl;

    logic clk;
    logic rst_n;
    logic btn_start_i;
    logic btn_pause_i;
    logic start, pause, clear, start_lvl, pause_lvl;

    int checks;
    int errors;

    stopwatch_button_ctrl #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start_i(btn_start_i),
        .btn_pause_i(btn_pause_i),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .start_lvl  (start_lvl),
        .pause_lvl  (pause_lvl)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; sample and drive 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Release both buttons and let the levels settle back to 0.
    task automatic release_all();
        btn_start_i = 1'b0;
        btn_pause_i = 1'b0;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        btn_start_i = 1'b1;
        btn_pause_i = 1'b1;

        // 1. reset with both buttons held
        for (int i = 0; i < 3; i++) tick();
        check("rst_start", start, 0);
        check("rst_pause", pause, 0);
        check("rst_clear", clear, 0);
        check("rst_start_lvl", start_lvl, 0);
        check("rst_pause_lvl", pause_lvl, 0);
        rst_n = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            tick();
            check("t1_pause", pause, (e == 5));
            check("t1_start", start, 0);
        end
        check("t1_start_lvl", start_lvl, 1);
        check("t1_pause_lvl", pause_lvl, 1);
        btn_start_i = 1'b0;
        btn_pause_i = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("t1_rel_lvl", start_lvl, (e < 5));
            check("t1_rel_pulse", {start, pause}, 0);
        end

        // 2. start held 20 cycles, then released
        btn_start_i = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("t2_start", start, (e == 5));
            check("t2_pause", pause, 0);
        end
        check("t2_start_lvl", start_lvl, 1);
        btn_start_i = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick();
            check("t2_rel_lvl", start_lvl, (e < 5));
            check("t2_rel_start", start, 0);
        end

        // 3. three-cycle glitch is ignored
        btn_start_i = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (e == 2) btn_start_i = 1'b0;
            check("t3_start", start, 0);
            check("t3_lvl", start_lvl, 0);
        end

        // 4. toggle 10 cycles, then steady high
        for (int i = 0; i < 10; i++) begin
            btn_start_i = ((i % 2) == 0);
            tick();
            check("t4_toggle_start", start, 0);
        end
        btn_start_i = 1'b1;
        for (int e = 0; e <= 8; e++) begin
            tick();
            check("t4_start", start, (e == 5));
        end
        check("t4_lvl", start_lvl, 1);
        release_all();
        check("t4_settled", {start_lvl, pause_lvl}, 0);

        // 5. both rise together: pause wins, start dropped
        btn_start_i = 1'b1;
        btn_pause_i = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            tick();
            check("t5_pause", pause, (e == 5));
            check("t5_start", start, 0);
        end
        check("t5_levels", {start_lvl, pause_lvl}, 2'b11);
        release_all();

        // 6. long pause hold
        btn_pause_i = 1'b1;
        for (int e = 0; e < 30; e++) begin
            tick();
            check("t6_pause", pause, (e == 5));
`ifdef LONG_PRESS_CLEAR_EN
            check("t6_clear", clear, (e == 21));
`else
            check("t6_clear", clear, 0);
`endif
        end
        release_all();
        check("t6_settled_clear", clear, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
